// File: rtl/qpu_trigger_scheduler.sv
// rtl/qpu_trigger_scheduler.sv - timed trigger event release scheduler
//
// Accepts timestamped trigger events into a FIFO and, while running, releases
// each one onto the trigger outputs on the edge where the timeline reaches its
// timestamp.
//
// Ports:
//   clk, rst_n          core clock, asynchronous active-low reset
//   i_start, i_stop     one-cycle pulses moving IDLE->RUN and RUN->IDLE
//   push_valid/ready    event handshake; push_ready = FIFO not full
//   push_time/data/mask event timestamp, data word and channel mask
//   o_time              timeline counter (0 in IDLE, saturates at all-ones)
//   o_clk_ena           high while running
//   o_data, o_valid     last released data word; one-cycle channel mask pulse
//   o_count             FIFO occupancy
//   o_late, o_ovf       sticky late-release and timeline-saturation flags

module qpu_trigger_scheduler #(
  parameter int TIME_W  = 32,
  parameter int DATA_W  = 16,
  parameter int EVT_NUM = 8,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [TIME_W-1:0]        push_time,
  input  logic [DATA_W-1:0]        push_data,
  input  logic [EVT_NUM-1:0]       push_mask,
  output logic [TIME_W-1:0]        o_time,
  output logic                     o_clk_ena,
  output logic [DATA_W-1:0]        o_data,
  output logic [EVT_NUM-1:0]       o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_late,
  output logic                     o_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TIME_W-1:0] TIME_MAX = '1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t state, state_nxt;

  logic [TIME_W-1:0]  mem_time [DEPTH];
  logic [DATA_W-1:0]  mem_data [DEPTH];
  logic [EVT_NUM-1:0] mem_mask [DEPTH];

  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count;
  logic [TIME_W-1:0]  t_next;
  logic               push_fire;
  logic               pop_fire;
  logic               time_clr;
  logic               time_adv;
  logic               flags_clr;

  // Ready depends on the registered count only, so a full FIFO refuses a
  // push even on an edge that also pops.
  assign push_ready = (count < CW'(DEPTH));
  assign push_fire  = push_valid & push_ready;
  assign o_count    = count;
  assign o_clk_ena  = (state == ST_RUN);

  // Value the timeline takes on the coming edge; it saturates rather than wraps.
  assign t_next = (o_time == TIME_MAX) ? TIME_MAX : o_time + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop_fire  = 1'b0;
    time_clr  = 1'b0;
    time_adv  = 1'b0;
    flags_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = ST_RUN;
          time_clr  = 1'b1;
          flags_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_nxt = ST_IDLE;
          time_clr  = 1'b1;
        end else begin
          time_adv = 1'b1;
          // Compare against t_next so the pulse lands in the cycle where
          // o_time equals the timestamp.
          pop_fire = (count != '0) && (mem_time[rd_ptr] <= t_next);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Storage carries no reset; validity is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_time[wr_ptr] <= push_time;
      mem_data[wr_ptr] <= push_data;
      mem_mask[wr_ptr] <= push_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_time  <= '0;
      o_data  <= '0;
      o_valid <= '0;
      o_late  <= 1'b0;
      o_ovf   <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      if (time_clr) begin
        o_time <= '0;
      end else if (time_adv) begin
        o_time <= t_next;
      end

      if (flags_clr) begin
        o_late <= 1'b0;
        o_ovf  <= 1'b0;
      end else begin
        if (time_adv && (t_next == TIME_MAX)) begin
          o_ovf <= 1'b1;
        end
        if (pop_fire && (mem_time[rd_ptr] < t_next)) begin
          o_late <= 1'b1;
        end
      end

      o_valid <= pop_fire ? mem_mask[rd_ptr] : '0;
      if (pop_fire) begin
        o_data <= mem_data[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_qpu_trigger_scheduler.sv
// tb/tb_qpu_trigger_scheduler.sv - randomized self-checking bench for qpu_trigger_scheduler

module tb_qpu_trigger_scheduler;

  localparam int TW    = 8;
  localparam int DW    = 16;
  localparam int EN    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int TMAX  = (1 << TW) - 1;

  logic          clk;
  logic          rst_n;
  logic          i_start;
  logic          i_stop;
  logic          push_valid;
  logic          push_ready;
  logic [TW-1:0] push_time;
  logic [DW-1:0] push_data;
  logic [EN-1:0] push_mask;
  logic [TW-1:0] o_time;
  logic          o_clk_ena;
  logic [DW-1:0] o_data;
  logic [EN-1:0] o_valid;
  logic [CW-1:0] o_count;
  logic          o_late;
  logic          o_ovf;

  qpu_trigger_scheduler #(
    .TIME_W (TW),
    .DATA_W (DW),
    .EVT_NUM(EN),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_time (push_time),
    .push_data (push_data),
    .push_mask (push_mask),
    .o_time    (o_time),
    .o_clk_ena (o_clk_ena),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_count   (o_count),
    .o_late    (o_late),
    .o_ovf     (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a pending-event queue plus the timeline rules.
  typedef struct {
    int t;
    int d;
    int m;
  } ev_t;

  ev_t q[$];
  bit  m_run;
  int  m_time;
  int  m_data;
  int  m_valid;
  bit  m_late;
  bit  m_ovf;
  bit  m_acc;

  function automatic void model_reset();
    q.delete();
    m_run = 0; m_time = 0; m_data = 0; m_valid = 0; m_late = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge();
    ev_t e;
    int  tn;
    m_acc   = push_valid && (q.size() < DEPTH);
    m_valid = 0;
    if (!m_run) begin
      if (i_start) begin
        m_run = 1; m_time = 0; m_late = 0; m_ovf = 0;
      end
    end else if (i_stop) begin
      m_run = 0; m_time = 0;
    end else begin
      tn = (m_time == TMAX) ? TMAX : m_time + 1;
      if (q.size() > 0 && q[0].t <= tn) begin
        e = q.pop_front();
        m_data  = e.d;
        m_valid = e.m;
        if (e.t < tn) m_late = 1;
      end
      m_time = tn;
      if (tn == TMAX) m_ovf = 1;
    end
    if (m_acc) begin
      e.t = int'(push_time); e.d = int'(push_data); e.m = int'(push_mask);
      q.push_back(e);
    end
  endfunction

  task automatic compare_all();
    check("o_time",     32'(o_time),     32'(m_time));
    check("o_clk_ena",  32'(o_clk_ena),  32'(m_run));
    check("o_data",     32'(o_data),     32'(m_data));
    check("o_valid",    32'(o_valid),    32'(m_valid));
    check("o_count",    32'(o_count),    32'(q.size()));
    check("o_late",     32'(o_late),     32'(m_late));
    check("o_ovf",      32'(o_ovf),      32'(m_ovf));
    check("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    i_start = 0; i_stop = 0; push_valid = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push1(input int t, input int d, input int m);
    push_valid = 1; push_time = TW'(t); push_data = DW'(d); push_mask = EN'(m);
    step();
  endtask

  task automatic go_idle();
    i_stop = 1;
    step();
  endtask

  task automatic go_start();
    i_start = 1;
    step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_time"},  32'(o_time),    0);
    check({tag, "_ena"},   32'(o_clk_ena), 0);
    check({tag, "_data"},  32'(o_data),    0);
    check({tag, "_valid"}, 32'(o_valid),   0);
    check({tag, "_count"}, 32'(o_count),   0);
    check({tag, "_late"},  32'(o_late),    0);
    check({tag, "_ovf"},   32'(o_ovf),     0);
    check({tag, "_ready"}, 32'(push_ready), 1);
  endtask

  initial begin
    int  tt;
    bit  got;
    rst_n = 0; i_start = 0; i_stop = 0; push_valid = 0;
    push_time = '0; push_data = '0; push_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1;

    // Two in-order events.
    push1(5, 'hAAAA, 'h01);
    push1(9, 'h1234, 'h82);
    go_start();
    cyc(11);
    check("s1_count", 32'(o_count), 0);
    check("s1_late",  32'(o_late),  0);

    // Fill the FIFO, then hold a ninth offer until it is taken.
    go_idle();
    for (int i = 0; i < DEPTH; i++) push1(2 + i, 'h100 + i, 1 << i);
    check("s2_full_ready", 32'(push_ready), 0);
    go_start();
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      push_valid = 1; push_time = TW'(20); push_data = DW'('hBEEF); push_mask = EN'('hFF);
      step();
      got = m_acc;
    end
    check("s2_ninth_accepted", 32'(got), 1);
    cyc(30);
    check("s2_drained", 32'(o_count), 0);

    // Equal timestamps, then restart clears the late flag.
    go_idle();
    push1(3, 'h0303, 'h04);
    push1(3, 'h3030, 'h08);
    go_start();
    cyc(6);
    check("s3_late", 32'(o_late), 1);
    go_idle();
    go_start();
    check("s3_late_clr", 32'(o_late), 0);

    // Event already in the past while running.
    go_idle();
    go_start();
    cyc(20);
    push1(10, 'h0A0A, 'h10);
    cyc(2);
    check("s4_late", 32'(o_late), 1);

    // Stop with an event pending, then restart.
    go_idle();
    push1(12, 'h1212, 'h20);
    go_start();
    cyc(7);
    go_idle();
    check("s5_stop_count", 32'(o_count), 1);
    go_start();
    cyc(14);
    check("s5_count", 32'(o_count), 0);

    // Zero-mask event followed by saturation with an event at all-ones.
    go_idle();
    push1(4, 'h4444, 'h00);
    push1(TMAX, 'hFFFF, 'h40);
    go_start();
    cyc(TMAX + 10);
    check("s6_ovf", 32'(o_ovf), 1);
    check("s6_time", 32'(o_time), TMAX);

    // Asynchronous reset mid-run.
    push1(TMAX, 'h5555, 'h01);
    push1(TMAX, 'h6666, 'h02);
    #3;
    rst_n = 0;
    #1;
    check_zero("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 45) begin
        if ($urandom_range(0, 9) == 0) tt = $urandom_range(0, m_time);
        else tt = m_time + $urandom_range(0, 25);
        if (tt > TMAX) tt = TMAX;
        push_valid = 1;
        push_time  = TW'(tt);
        push_data  = DW'($urandom);
        push_mask  = ($urandom_range(0, 7) == 0) ? '0 : EN'($urandom);
      end
      i_start = ($urandom_range(0, 19) == 0);
      i_stop  = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
